// File: rtl/da_lut_sram_ctrl_if.sv
// Bus bundle for the DA LUT SRAM controller: load stream, read request/response and SRAM pins.
// Optional DA_LUT_LOAD_CKSUM_EN adds the load_cksum signal.
interface da_lut_sram_ctrl_if #(
  parameter int DW   = 20,
  parameter int AW   = 8,
  parameter int BLKS = 8
);
  localparam int CW = $clog2(BLKS) + AW;

  // load stream
  logic                 start;
  logic                 s_valid;
  logic [DW-1:0]        s_data;
  logic                 s_ready;
  logic                 load_done;

  // read request / response
  logic                 rd_valid;
  logic [BLKS*AW-1:0]   rd_addr;
  logic                 out_valid;
  logic [BLKS*DW-1:0]   out_q;

  // SRAM pins
  logic                 sram_cen;
  logic                 sram_wen;
  logic [CW-1:0]        sram_caddr;
  logic [DW-1:0]        sram_d;
  logic [BLKS*AW-1:0]   sram_a;
  logic [BLKS*DW-1:0]   sram_q;

`ifdef DA_LUT_LOAD_CKSUM_EN
  logic [DW+3:0]        load_cksum;
`endif

  // Controller side
  modport slave (
    input  start, s_valid, s_data, rd_valid, rd_addr, sram_q,
    output s_ready, load_done, out_valid, out_q,
           sram_cen, sram_wen, sram_caddr, sram_d, sram_a
`ifdef DA_LUT_LOAD_CKSUM_EN
    , output load_cksum
`endif
  );

  // Environment side: LUT producer, read client and SRAM macro
  modport master (
    output start, s_valid, s_data, rd_valid, rd_addr, sram_q,
    input  s_ready, load_done, out_valid, out_q,
           sram_cen, sram_wen, sram_caddr, sram_d, sram_a
`ifdef DA_LUT_LOAD_CKSUM_EN
    , input load_cksum
`endif
  );

endinterface

// File: rtl/da_lut_sram_ctrl.sv
// Initiator-side controller for the banked DA LUT SRAM: sequential LOAD, then parallel RUN reads.
// Define DA_LUT_LOAD_CKSUM_EN to add a modular checksum of the loaded words (load_cksum).
module da_lut_sram_ctrl #(
  parameter int DW     = 20,
  parameter int AW     = 8,
  parameter int BLKS   = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  da_lut_sram_ctrl_if.slave bus
);

  localparam int CW     = $clog2(BLKS) + AW;
  localparam int NWORDS = BLKS << AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic [CW-1:0]       cnt_q,       cnt_d;
  logic                s_ready_q,   s_ready_d;
  logic                load_done_q, load_done_d;
  logic                cen_q,       cen_d;
  logic                wen_q,       wen_d;
  logic [CW-1:0]       caddr_q,     caddr_d;
  logic [DW-1:0]       wdata_q,     wdata_d;
  logic [BLKS*AW-1:0]  raddr_q,     raddr_d;
  logic [RD_LAT:0]     vld_q,       vld_d;
  logic                out_valid_q, out_valid_d;
  logic [BLKS*DW-1:0]  out_q_q,     out_q_d;

  logic wr_go;
  logic rd_go;
  logic last_word;

  // start overrides both a load handshake and a read request in the same cycle
  assign wr_go     = s_ready_q && bus.s_valid && !bus.start;
  assign rd_go     = load_done_q && bus.rd_valid && !bus.start;
  assign last_word = (cnt_q == CW'(NWORDS - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    caddr_d     = caddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;

    case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        if (wr_go) begin
          cnt_d   = cnt_q + CW'(1);
          caddr_d = cnt_q;
          wdata_d = bus.s_data;
          if (last_word) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_go) raddr_d = bus.rd_addr;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end

    s_ready_d   = (state_d == ST_LOAD);
    // load_done trails entry into RUN by one cycle, i.e. after the last write is on the bus
    load_done_d = (state_q == ST_RUN) && !bus.start;
    cen_d       = !(wr_go || rd_go);
    wen_d       = !wr_go;

    // Read-valid pipe: bit 0 marks the cycle the read is on the bus, bit RD_LAT the cycle Q is valid
    vld_d       = {vld_q[RD_LAT-1:0], rd_go};
    out_valid_d = vld_q[RD_LAT];
    out_q_d     = vld_q[RD_LAT] ? bus.sram_q : out_q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      load_done_q <= 1'b0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      caddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, avoiding order races.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      load_done_q <= load_done_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      caddr_q     <= caddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_q      = out_q_q;
  assign bus.sram_cen   = cen_q;
  assign bus.sram_wen   = wen_q;
  assign bus.sram_caddr = caddr_q;
  assign bus.sram_d     = wdata_q;
  assign bus.sram_a     = raddr_q;

`ifdef DA_LUT_LOAD_CKSUM_EN
  logic [DW+3:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (bus.start)  cksum_d = '0;
    else if (wr_go) cksum_d = cksum_q + {4'b0, bus.s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign bus.load_cksum = cksum_q;
`endif

endmodule
